stopwatch_display_scanner: RTL and testbench

- Downstream consumer of the stopwatch counter's packed BCD value (MM:SS, 4 digits × 4 bits).
- Time-multiplexes the four digits onto a common-anode 4-digit seven-segment display.
- Provides an anti-ghost blanking interval, minutes-tens leading-zero suppression and a colon/decimal-point indicator.
- Latches a tear-free snapshot of the counter value once per full scan.

---
 rtl/stopwatch_display_scanner.sv | 120 ++++++++++++
 tb/tb_stopwatch_display_scanner.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_display_scanner.sv
`default_nettype none
// ============================================================================
// Module   : stopwatch_display_scanner
// Purpose  : Multiplexes a packed BCD MM:SS value onto a common-anode 4-digit
//            seven-segment display with blanking, leading-zero and colon dp.
// Revision : 1.0 - initial release
// ============================================================================
module stopwatch_display_scanner #(
  parameter int BOARD_CLOCK_FREQUENCY_IN_HZ = 100_000_000,
  parameter int DIGIT_REFRESH_RATE_IN_HZ    = 1000,
  parameter int BLANK_CYCLES                = 16,
  parameter int NUMBER_OF_DIGITS            = 4,
  parameter int NUMBER_OF_BITS_PER_DIGIT    = 4,
  parameter bit LEADING_ZERO_BLANK          = 1'b1
) (
  input  logic                                                  clk,
  input  logic                                                  rst,
  input  logic                                                  enable,
  input  logic [NUMBER_OF_DIGITS*NUMBER_OF_BITS_PER_DIGIT-1:0] number,
  input  logic                                                  colon,
  output logic [6:0]                                            segments,
  output logic                                                  dp,
  output logic [NUMBER_OF_DIGITS-1:0]                           digit_select
);

  localparam int c_dwell = BOARD_CLOCK_FREQUENCY_IN_HZ / DIGIT_REFRESH_RATE_IN_HZ;
  localparam int c_p_w   = (c_dwell > 1) ? $clog2(c_dwell) : 1;
  localparam int c_idx_w = (NUMBER_OF_DIGITS > 1) ? $clog2(NUMBER_OF_DIGITS) : 1;
  localparam int c_num_w = NUMBER_OF_DIGITS * NUMBER_OF_BITS_PER_DIGIT;

  localparam logic [c_p_w-1:0]            c_p_last    = c_p_w'(c_dwell - 1);
  localparam logic [c_p_w-1:0]            c_p_blank   = c_p_w'(BLANK_CYCLES);
  localparam logic [c_idx_w-1:0]          c_idx_last  = c_idx_w'(NUMBER_OF_DIGITS - 1);
  localparam logic [c_idx_w-1:0]          c_idx_colon = c_idx_w'(2);
  localparam logic [6:0]                  c_seg_off   = 7'h7F;
  localparam logic [NUMBER_OF_DIGITS-1:0] c_sel_off   = '1;
  localparam logic [NUMBER_OF_DIGITS-1:0] c_sel_one   = NUMBER_OF_DIGITS'(1);

  logic [c_p_w-1:0]                    r_p;
  logic [c_idx_w-1:0]                  r_idx;
  logic [c_num_w-1:0]                  r_snapshot;
  logic                                r_first;

  logic [NUMBER_OF_BITS_PER_DIGIT-1:0] w_digit;
  logic                                w_active;
  logic                                w_lz_blank;
  logic [6:0]                          w_seg_next;
  logic [NUMBER_OF_DIGITS-1:0]         w_sel_next;
  logic                                w_dp_next;

  // Active-low gfedcba; anything beyond 9 renders as a dash.
  function automatic logic [6:0] decode(input logic [NUMBER_OF_BITS_PER_DIGIT-1:0] value);
    case (int'(value))
      0:       decode = 7'b1000000;
      1:       decode = 7'b1111001;
      2:       decode = 7'b0100100;
      3:       decode = 7'b0110000;
      4:       decode = 7'b0011001;
      5:       decode = 7'b0010010;
      6:       decode = 7'b0000010;
      7:       decode = 7'b1111000;
      8:       decode = 7'b0000000;
      9:       decode = 7'b0010000;
      default: decode = 7'b0111111;
    endcase
  endfunction

  always_comb begin
    w_digit = '0;
    for (int i = 0; i < NUMBER_OF_DIGITS; i++) begin
      if (r_idx == c_idx_w'(i)) begin
        w_digit = r_snapshot[i*NUMBER_OF_BITS_PER_DIGIT +: NUMBER_OF_BITS_PER_DIGIT];
      end
    end
  end

  // The blank interval at the head of every dwell hides the digit change.
  assign w_active   = (r_p >= c_p_blank);
  assign w_lz_blank = LEADING_ZERO_BLANK && (r_idx == c_idx_last) && (w_digit == '0);
  assign w_seg_next = (!w_active || w_lz_blank) ? c_seg_off : decode(w_digit);
  assign w_sel_next = w_active ? ~(c_sel_one << r_idx) : c_sel_off;
  assign w_dp_next  = !(w_active && (r_idx == c_idx_colon) && colon);

  // rst is active-low and asynchronous.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_p          <= '0;
      r_idx        <= '0;
      r_snapshot   <= '0;
      r_first      <= 1'b1;
      segments     <= c_seg_off;
      dp           <= 1'b1;
      digit_select <= c_sel_off;
    end else if (!enable) begin
      r_p          <= '0;
      r_idx        <= '0;
      r_first      <= 1'b1;
      segments     <= c_seg_off;
      dp           <= 1'b1;
      digit_select <= c_sel_off;
    end else begin
      r_p <= (r_p == c_p_last) ? '0 : r_p + 1'b1;
      if (r_p == c_p_last) begin
        r_idx <= (r_idx == c_idx_last) ? '0 : r_idx + 1'b1;
      end
      // Snapshot only at scan wrap (or first enabled clock) so digits never tear.
      if (r_first) begin
        r_snapshot <= number;
        r_first    <= 1'b0;
      end else if ((r_p == c_p_last) && (r_idx == c_idx_last)) begin
        r_snapshot <= number;
      end
      segments     <= w_seg_next;
      dp           <= w_dp_next;
      digit_select <= w_sel_next;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_stopwatch_display_scanner.sv
`default_nettype none
// Directed bench for stopwatch_display_scanner with DWELL=10, BLANK_CYCLES=2.
module tb_stopwatch_display_scanner;

  localparam int BOARD = 1000;
  localparam int REFRESH = 100;
  localparam int BLANK = 2;
  localparam logic [3:0] SEL_T [4] = '{4'hE, 4'hD, 4'hB, 4'h7};

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        enable = 1'b0;
  logic        colon = 1'b0;
  logic [15:0] number = 16'h0000;
  logic [6:0]  segments;
  logic        dp;
  logic [3:0]  digit_select;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  stopwatch_display_scanner #(
    .BOARD_CLOCK_FREQUENCY_IN_HZ(BOARD),
    .DIGIT_REFRESH_RATE_IN_HZ(REFRESH),
    .BLANK_CYCLES(BLANK),
    .NUMBER_OF_DIGITS(4),
    .NUMBER_OF_BITS_PER_DIGIT(4),
    .LEADING_ZERO_BLANK(1'b1)
  ) dut (
    .clk(clk),
    .rst(rst_n),
    .enable(enable),
    .number(number),
    .colon(colon),
    .segments(segments),
    .dp(dp),
    .digit_select(digit_select)
  );

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic restart(input logic [15:0] value);
    enable = 1'b0;
    number = value;
    step();
    enable = 1'b1;
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    enable = 1'b1;
    number = 16'h1234;
    #1;
    checks++;
    if ({digit_select, segments, dp} !== {4'hF, 7'h7F, 1'b1}) begin
      errors++;
      $display("FAIL reset_async: sel=%h seg=%h dp=%b, expected sel=F seg=7F dp=1", digit_select, segments, dp);
    end
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if ({digit_select, segments, dp} !== {4'hF, 7'h7F, 1'b1}) begin
        errors++;
        $display("FAIL reset_hold %0d: sel=%h seg=%h dp=%b, expected sel=F seg=7F dp=1", k, digit_select, segments, dp);
      end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_scan();
    logic [6:0] seg_t [4];
    logic [3:0] es;
    logic [6:0] eg;
    seg_t = '{7'h19, 7'h30, 7'h24, 7'h79};
    for (int s = 0; s < 2; s++)
      for (int d = 0; d < 4; d++)
        for (int c = 0; c < 10; c++) begin
          step();
          es = (c < BLANK) ? 4'hF : SEL_T[d];
          eg = (c < BLANK) ? 7'h7F : seg_t[d];
          checks++;
          if ({digit_select, segments, dp} !== {es, eg, 1'b1}) begin
            errors++;
            $display("FAIL scan s%0d d%0d c%0d: sel=%h seg=%h dp=%b, expected sel=%h seg=%h dp=1",
                     s, d, c, digit_select, segments, dp, es, eg);
          end
        end
  endtask

  task automatic test_leading_zero();
    logic [6:0] seg_t [4];
    logic [3:0] es;
    logic [6:0] eg;
    seg_t = '{7'h12, 7'h40, 7'h10, 7'h7F};
    restart(16'h0905);
    for (int d = 0; d < 4; d++)
      for (int c = 0; c < 10; c++) begin
        step();
        es = (c < BLANK) ? 4'hF : SEL_T[d];
        eg = (c < BLANK) ? 7'h7F : seg_t[d];
        checks++;
        if ({digit_select, segments} !== {es, eg}) begin
          errors++;
          $display("FAIL lzb d%0d c%0d: sel=%h seg=%h, expected sel=%h seg=%h", d, c, digit_select, segments, es, eg);
        end
      end
  endtask

  task automatic test_snapshot();
    logic [6:0] seg_t [8];
    logic [3:0] es;
    logic [6:0] eg;
    seg_t = '{7'h19, 7'h30, 7'h24, 7'h79, 7'h00, 7'h78, 7'h02, 7'h12};
    restart(16'h1234);
    for (int s = 0; s < 2; s++)
      for (int d = 0; d < 4; d++)
        for (int c = 0; c < 10; c++) begin
          if (s == 0 && d == 1 && c == 5) number = 16'h5678;
          step();
          es = (c < BLANK) ? 4'hF : SEL_T[d];
          eg = (c < BLANK) ? 7'h7F : seg_t[s*4+d];
          checks++;
          if ({digit_select, segments} !== {es, eg}) begin
            errors++;
            $display("FAIL snapshot s%0d d%0d c%0d: sel=%h seg=%h, expected sel=%h seg=%h",
                     s, d, c, digit_select, segments, es, eg);
          end
        end
  endtask

  task automatic test_colon();
    logic ed;
    colon = 1'b1;
    restart(16'h1234);
    for (int d = 0; d < 4; d++)
      for (int c = 0; c < 10; c++) begin
        step();
        ed = !(d == 2 && c >= BLANK);
        checks++;
        if (dp !== ed) begin
          errors++;
          $display("FAIL colon d%0d c%0d: dp=%b, expected dp=%b", d, c, dp, ed);
        end
      end
    colon = 1'b0;
  endtask

  task automatic test_dash();
    logic [6:0] seg_t [4];
    logic [6:0] eg;
    seg_t = '{7'h3F, 7'h3F, 7'h40, 7'h7F};
    restart(16'h00AF);
    for (int d = 0; d < 4; d++)
      for (int c = 0; c < 10; c++) begin
        step();
        eg = (c < BLANK) ? 7'h7F : seg_t[d];
        checks++;
        if (segments !== eg) begin
          errors++;
          $display("FAIL dash d%0d c%0d: seg=%h, expected seg=%h", d, c, segments, eg);
        end
      end
  endtask

  task automatic test_enable_drop();
    logic [3:0] es;
    logic [6:0] eg;
    restart(16'h1234);
    for (int k = 1; k <= 25; k++) step();
    checks++;
    if ({digit_select, segments} !== {4'hB, 7'h24}) begin
      errors++;
      $display("FAIL pre_drop: sel=%h seg=%h, expected sel=B seg=24", digit_select, segments);
    end
    enable = 1'b0;
    for (int k = 0; k < 2; k++) begin
      step();
      checks++;
      if ({digit_select, segments, dp} !== {4'hF, 7'h7F, 1'b1}) begin
        errors++;
        $display("FAIL disabled %0d: sel=%h seg=%h dp=%b, expected sel=F seg=7F dp=1", k, digit_select, segments, dp);
      end
    end
    number = 16'h5678;
    enable = 1'b1;
    for (int c = 0; c < 10; c++) begin
      step();
      es = (c < BLANK) ? 4'hF : 4'hE;
      eg = (c < BLANK) ? 7'h7F : 7'h00;
      checks++;
      if ({digit_select, segments} !== {es, eg}) begin
        errors++;
        $display("FAIL reenable c%0d: sel=%h seg=%h, expected sel=%h seg=%h", c, digit_select, segments, es, eg);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [3:0] es;
    logic [6:0] eg;
    restart(16'h1234);
    for (int k = 1; k <= 15; k++) step();
    checks++;
    if ({digit_select, segments} !== {4'hD, 7'h30}) begin
      errors++;
      $display("FAIL pre_reset: sel=%h seg=%h, expected sel=D seg=30", digit_select, segments);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({digit_select, segments, dp} !== {4'hF, 7'h7F, 1'b1}) begin
      errors++;
      $display("FAIL mid_reset: sel=%h seg=%h dp=%b, expected sel=F seg=7F dp=1", digit_select, segments, dp);
    end
    number = 16'h0905;
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      step();
      es = (c < BLANK) ? 4'hF : 4'hE;
      eg = (c < BLANK) ? 7'h7F : 7'h12;
      checks++;
      if ({digit_select, segments} !== {es, eg}) begin
        errors++;
        $display("FAIL post_reset c%0d: sel=%h seg=%h, expected sel=%h seg=%h", c, digit_select, segments, es, eg);
      end
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_leading_zero();
    test_snapshot();
    test_colon();
    test_dash();
    test_enable_drop();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
